// File: rtl/conv_tile_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : conv_tile_seq_if
// Brief   : Bundle of config, weight-source, xmem and core_ctrl signals
//           seen by the convolution tile sequencer.
//           master = sequencer side, slave = host/source/core side.
// Revision: 1.0 - initial release
// ============================================================================
interface conv_tile_seq_if #(
  parameter int TILE_W = 4,
  parameter int SRC_AW = 16,
  parameter int ADDR_W = 11
);
  // host configuration
  logic              cfg_start;
  logic              cfg_abort;
  logic [TILE_W-1:0] cfg_n_tiles;
  logic              busy;
  logic              done;
  // external weight source
  logic              wsrc_req;
  logic [SRC_AW-1:0] wsrc_addr;
  logic [31:0]       wsrc_data;
  logic              wsrc_valid;
  // xmem write port
  logic              xmem_cen;
  logic              xmem_wen;
  logic [ADDR_W-1:0] xmem_addr;
  logic [31:0]       xmem_din;
  // core_ctrl control
  logic              core_rst;
  logic [3:0]        core_inst;
  logic [3:0]        core_kij;
  logic              core_done;

  modport master (
    input  cfg_start, cfg_abort, cfg_n_tiles, wsrc_data, wsrc_valid, core_done,
    output busy, done, wsrc_req, wsrc_addr, xmem_cen, xmem_wen, xmem_addr,
           xmem_din, core_rst, core_inst, core_kij
  );

  modport slave (
    output cfg_start, cfg_abort, cfg_n_tiles, wsrc_data, wsrc_valid, core_done,
    input  busy, done, wsrc_req, wsrc_addr, xmem_cen, xmem_wen, xmem_addr,
           xmem_din, core_rst, core_inst, core_kij
  );
endinterface
`default_nettype wire

// File: rtl/conv_tile_seq.sv
`default_nettype none
// ============================================================================
// Module  : conv_tile_seq
// Brief   : Per-layer sequencer for core_ctrl. For each output-channel tile
//           it clears psum memory, then for every kij soft-resets the core,
//           loads the kernel slice from the weight source into xmem and runs
//           the core via start/done, and finally drains the psums.
//           Optional macro SEQ_PERF_CNT_EN adds the o_perf_wait stall counter.
// Revision: 1.0 - initial release
// ============================================================================
module conv_tile_seq #(
  parameter int K        = 3,
  parameter int COL      = 8,
  parameter int LEN_NIJ  = 16,
  parameter int ADDR_W   = 11,
  parameter int WGT_BASE = 1024,
  parameter int RST_CYC  = 5,
  parameter int TILE_W   = 4,
  parameter int SRC_AW   = 16
) (
  input  wire              clk,
  input  wire              reset,
  conv_tile_seq_if.master  bus
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      o_perf_wait
`endif
);

  localparam int KK    = K * K;
  localparam int CNT_W = $clog2(LEN_NIJ + RST_CYC + 3);
  localparam int W_W   = $clog2(COL) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_PRERST = 3'd2,
    S_WLOAD  = 3'd3,
    S_RUN    = 3'd4,
    S_RUNLOW = 3'd5,
    S_DRAIN  = 3'd6,
    S_FIN    = 3'd7
  } state_t;

  state_t            r_state;
  logic [TILE_W-1:0] r_tiles;
  logic [TILE_W-1:0] r_tile;
  logic [3:0]        r_kij;
  logic [W_W-1:0]    r_w;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_wdone;

  logic              r_busy;
  logic              r_done;
  logic              r_wsrc_req;
  logic [SRC_AW-1:0] r_wsrc_addr;
  logic              r_xmem_cen;
  logic              r_xmem_wen;
  logic [ADDR_W-1:0] r_xmem_addr;
  logic [31:0]       r_xmem_din;
  logic              r_core_rst;
  logic [3:0]        r_core_inst;
  logic [3:0]        r_core_kij;

  logic [SRC_AW-1:0] w_slice_base;
  logic [3:0]        w_kij_inc;
  logic [TILE_W:0]   w_tile_inc;

  // first weight-source word of the current (tile, kij) slice
  assign w_slice_base = SRC_AW'((32'(r_tile) * 32'(KK) + 32'(r_kij)) * 32'(COL));
  assign w_kij_inc    = r_kij + 4'd1;
  assign w_tile_inc   = {1'b0, r_tile} + (TILE_W+1)'(1);

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.wsrc_req  = r_wsrc_req;
  assign bus.wsrc_addr = r_wsrc_addr;
  assign bus.xmem_cen  = r_xmem_cen;
  assign bus.xmem_wen  = r_xmem_wen;
  assign bus.xmem_addr = r_xmem_addr;
  assign bus.xmem_din  = r_xmem_din;
  assign bus.core_rst  = r_core_rst;
  assign bus.core_inst = r_core_inst;
  assign bus.core_kij  = r_core_kij;

  // Layer sequencing FSM; every output is set on the edge that enters the
  // state it belongs to, so each phase length equals its state residency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tiles     <= '0;
      r_tile      <= '0;
      r_kij       <= '0;
      r_w         <= '0;
      r_cnt       <= '0;
      r_wdone     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wsrc_req  <= 1'b0;
      r_wsrc_addr <= '0;
      r_xmem_cen  <= 1'b1;
      r_xmem_wen  <= 1'b1;
      r_xmem_addr <= '0;
      r_xmem_din  <= '0;
      r_core_rst  <= 1'b0;
      r_core_inst <= '0;
      r_core_kij  <= '0;
    end else begin
      // single-cycle strobes fall back to idle unless re-asserted below
      r_done     <= 1'b0;
      r_xmem_cen <= 1'b1;
      r_xmem_wen <= 1'b1;

      if (bus.cfg_abort && (r_state != S_IDLE)) begin
        // abort wins over every transition and never produces done
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_wsrc_req  <= 1'b0;
        r_wdone     <= 1'b0;
        r_core_rst  <= 1'b0;
        r_core_inst <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.cfg_start) begin
              r_tiles <= bus.cfg_n_tiles;
              r_tile  <= '0;
              r_kij   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              if (bus.cfg_n_tiles == '0) begin
                r_state <= S_FIN;
              end else begin
                r_state     <= S_CLEAR;
                r_core_inst <= 4'b0010;
              end
            end
          end

          S_CLEAR: begin
            if (r_cnt == CNT_W'(LEN_NIJ + 1)) begin
              r_cnt       <= '0;
              r_state     <= S_PRERST;
              r_core_rst  <= 1'b1;
              r_core_kij  <= r_kij;
              r_core_inst <= {1'b0, r_kij[0], 2'b00};
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          S_PRERST: begin
            if (r_cnt == CNT_W'(RST_CYC - 1)) begin
              r_core_rst <= 1'b0;
            end
            if (r_cnt == CNT_W'(RST_CYC)) begin
              r_cnt       <= '0;
              r_state     <= S_WLOAD;
              r_w         <= '0;
              r_wdone     <= 1'b0;
              r_wsrc_req  <= 1'b1;
              r_wsrc_addr <= w_slice_base;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          S_WLOAD: begin
            if (r_wdone) begin
              // last xmem write has been on the bus for one cycle
              r_state        <= S_RUN;
              r_core_inst[0] <= 1'b1;
            end else if (r_wsrc_req && bus.wsrc_valid) begin
              r_xmem_cen  <= 1'b0;
              r_xmem_wen  <= 1'b0;
              r_xmem_addr <= ADDR_W'(WGT_BASE) + ADDR_W'(r_w);
              r_xmem_din  <= bus.wsrc_data;
              if (r_w == W_W'(COL - 1)) begin
                r_wsrc_req <= 1'b0;
                r_wdone    <= 1'b1;
              end else begin
                r_w         <= r_w + W_W'(1);
                r_wsrc_addr <= r_wsrc_addr + SRC_AW'(1);
              end
            end
          end

          S_RUN: begin
            if (bus.core_done) begin
              r_core_inst[0] <= 1'b0;
              r_state        <= S_RUNLOW;
            end
          end

          S_RUNLOW: begin
            if (r_kij != 4'(KK - 1)) begin
              r_kij       <= w_kij_inc;
              r_state     <= S_PRERST;
              r_core_rst  <= 1'b1;
              r_core_kij  <= w_kij_inc;
              r_core_inst <= {1'b0, w_kij_inc[0], 2'b00};
            end else begin
              r_cnt       <= '0;
              r_state     <= S_DRAIN;
              r_core_inst <= 4'b1000;
            end
          end

          S_DRAIN: begin
            if (r_cnt == CNT_W'(LEN_NIJ - 1)) begin
              r_cnt  <= '0;
              r_tile <= w_tile_inc[TILE_W-1:0];
              if (w_tile_inc < {1'b0, r_tiles}) begin
                r_kij       <= '0;
                r_state     <= S_CLEAR;
                r_core_inst <= 4'b0010;
              end else begin
                r_state     <= S_FIN;
                r_core_inst <= '0;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          S_FIN: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_perf_wait;
  logic        w_perf_inc;

  assign w_perf_inc = ((r_state == S_RUN) && !bus.core_done) ||
                      ((r_state == S_WLOAD) && r_wsrc_req && !bus.wsrc_valid);
  assign o_perf_wait = r_perf_wait;

  // Saturating stall counter: core wait cycles plus weight-source wait cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_wait <= '0;
    end else if ((r_state == S_IDLE) && bus.cfg_start) begin
      r_perf_wait <= '0;
    end else if (w_perf_inc && (r_perf_wait != '1)) begin
      r_perf_wait <= r_perf_wait + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/conv_tile_seq.md
Name: conv_tile_seq

Overview:
- Hardware sequencer that replaces bench-driven stepping of core_ctrl for one convolution layer.
- Per output-channel tile it:
  - clears the psum memory,
  - loops kij = 0..K*K-1, fetching each kernel slice from an external weight source into xmem, then running core_ctrl via start/done,
  - drains final psums.
- Sits between the top-level host/config and core_ctrl; drives core_ctrl's inst, kij and xmem write ports.
- Generalises the bench flow to parametrised K, tile count, slice length and a psum-clear phase.

Parameters:
- K, 3, kernel side; K*K kij positions per tile.
- COL, 8, weight words per kij slice.
- LEN_NIJ, 16, output pixels; length of clear and drain phases.
- ADDR_W, 11, xmem address width.
- WGT_BASE, 1024, xmem address of weight slot (word 0 of the slice).
- RST_CYC, 5, core soft-reset cycles before each kij.
- TILE_W, 4, width of tile count.
- SRC_AW, 16, weight-source address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- cfg_start  in  1  one-cycle start pulse; ignored while busy
- cfg_abort  in  1  synchronous abort
- cfg_n_tiles  in  TILE_W  tiles to run; sampled on accepted cfg_start
- busy  out  1  high from the cycle after cfg_start until done/abort
- done  out  1  one-cycle pulse at layer end
- wsrc_req  out  1  weight read request (one outstanding)
- wsrc_addr  out  SRC_AW  word address = (tile*K*K + kij)*COL + w
- wsrc_data  in  32  returned word
- wsrc_valid  in  1  data valid, ≥1 cycle after req
- xmem_cen  out  1  active-low
- xmem_wen  out  1  active-low
- xmem_addr  out  ADDR_W  xmem address
- xmem_din  out  32  xmem write data
- core_rst  out  1  core soft reset
- core_inst  out  4  [3] final_mem_read, [2] rchip, [1] mem_write, [0] start
- core_kij  out  4  current kij
- core_done  in  1  core_ctrl done

Behaviour:
- Async reset clears all state. Reset values of outputs:
  - state IDLE
  - busy = 0, done = 0, wsrc_req = 0
  - xmem_cen = 1, xmem_wen = 1
  - core_rst = 0, core_inst = 0, core_kij = 0
- All outputs are registered.
- States: IDLE → CLEAR → PRERST → WLOAD → RUN → RUNLOW → (PRERST | DRAIN) → (CLEAR | FIN) → IDLE.
- IDLE:
  - on cfg_start, latch n_tiles and go to CLEAR.
  - if cfg_n_tiles = 0: go to FIN directly, so done pulses 2 cycles after cfg_start with no other activity.
- CLEAR: mem_write = 1 for exactly LEN_NIJ+2 cycles; tile counter reset of kij = 0.
- PRERST:
  - core_kij = kij, rchip = kij[0].
  - core_rst = 1 for RST_CYC cycles, then 1 idle cycle.
- WLOAD, for w = 0..COL-1:
  - assert wsrc_req with wsrc_addr.
  - hold request until wsrc_valid.
  - in the wsrc_valid cycle, register a write: xmem_cen = 0, xmem_wen = 0, xmem_addr = WGT_BASE+w, xmem_din = wsrc_data.
  - wsrc_valid while no request is outstanding is ignored.
  - after COL writes, xmem_cen/xmem_wen return to 1 the next cycle, then go to RUN.
- RUN:
  - start = 1 held until core_done is seen high.
  - a core_done already high on RUN entry counts (minimum 1 RUN cycle).
- RUNLOW:
  - start = 0 for 1 cycle.
  - if kij < K*K-1: kij++ and go to PRERST.
  - else go to DRAIN.
- DRAIN: final_mem_read = 1 for LEN_NIJ cycles. Then tile++; if tile < n_tiles go to CLEAR, else go to FIN.
- FIN: done = 1 for 1 cycle, busy drops in the same cycle, then IDLE.
- Priority: cfg_abort in any non-IDLE state takes priority over all transitions.
  - Next cycle: IDLE, all core_inst bits 0, wsrc_req 0, xmem idle.
  - No done pulse.
  - A late wsrc_valid after abort is ignored.
- Counters wrap only at their configured limits; no counter overflows for legal parameters.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- When defined:
  - adds output perf_wait (32 bits), counting RUN cycles with core_done = 0 plus WLOAD cycles with wsrc_req = 1 and wsrc_valid = 0.
  - cleared on accepted cfg_start; holds its value in IDLE; saturates at all-ones.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- n_tiles = 1, wsrc_valid 1 cycle after req, core_done 4 cycles after start → 9 kij runs, kij 0..8; rchip 0,1,0,…; 72 xmem writes at addresses 1024..1031 repeated; mem_write 18 cycles; final_mem_read 16 cycles; 1 done pulse.
- n_tiles = 2 → wsrc_addr of tile 1 kij 0 word 0 = 72; two CLEAR/DRAIN phases; single done.
- Source stalls 3 cycles per word → wsrc_req held steady with a constant address; exactly 8 writes per kij; data matches the source.
- cfg_abort mid-RUN at kij 4 → next cycle IDLE, core_inst = 0, busy = 0, no done; a new cfg_start restarts at tile 0, kij 0.
- cfg_n_tiles = 0 → done 2 cycles after start, no wsrc_req, no core_inst activity; cfg_start while busy ignored.
- Async reset mid-WLOAD → outputs immediately at reset values; with SEQ_PERF_CNT_EN, a 3-cycle stall per word gives perf_wait = 24 per kij plus RUN waits.
